// File: rtl/id_ex_pipeline_register.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_register
// Decode-to-execute pipeline register of the segmented RV32I core.
// Captures the decode-stage control bundle and operands every cycle and
// presents them to EX. Detects load-use hazards against the instruction
// currently in EX (stalling IF/ID and inserting a bubble), honours a
// branch-redirect Flush and a global Hold, and keeps saturating stall and
// flush event counters.
//
// Ports:
//   Clk, Reset           rising-edge clock, synchronous active-high reset
//   Hold                 freeze the whole register (memory wait)
//   Flush                branch/jump taken in EX; kill instruction entering EX
//   *_D                  decode-stage control, operands and register indices
//   *_E                  registered EX-stage copies (Valid_E included)
//   Stall                combinational; freeze PC and IF/ID this cycle
//   StallCount           saturating count of load-use bubbles
//   FlushCount           saturating count of flush cycles
// -----------------------------------------------------------------------------
module id_ex_pipeline_register #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Hold,
   input  logic             Flush,
   input  logic             Valid_D,
   input  logic             ALUASrc_D,
   input  logic             ALUBSrc_D,
   input  logic             DMWr_D,
   input  logic             RUWr_D,
   input  logic [3:0]       ALUOp_D,
   input  logic [4:0]       BrOp_D,
   input  logic [2:0]       DMCtrl_D,
   input  logic [1:0]       RUDATAWrSrc_D,
   input  logic [XLEN-1:0]  PC_D,
   input  logic [XLEN-1:0]  RS1Data_D,
   input  logic [XLEN-1:0]  RS2Data_D,
   input  logic [XLEN-1:0]  Imm_D,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       Rd_D,
   output logic             Valid_E,
   output logic             ALUASrc_E,
   output logic             ALUBSrc_E,
   output logic             DMWr_E,
   output logic             RUWr_E,
   output logic [3:0]       ALUOp_E,
   output logic [4:0]       BrOp_E,
   output logic [2:0]       DMCtrl_E,
   output logic [1:0]       RUDATAWrSrc_E,
   output logic [XLEN-1:0]  PC_E,
   output logic [XLEN-1:0]  RS1Data_E,
   output logic [XLEN-1:0]  RS2Data_E,
   output logic [XLEN-1:0]  Imm_E,
   output logic [4:0]       Rs1_E,
   output logic [4:0]       Rs2_E,
   output logic [4:0]       Rd_E,
   output logic             Stall,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   // 19 bits of control + four XLEN operands + three 5-bit indices
   localparam int unsigned BW = 4 * XLEN + 34;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [BW-1:0]    BUBBLE   = {BW{1'b0}};

   logic [BW-1:0]    d_bundle_s;
   logic [BW-1:0]    pipe_d;
   logic [BW-1:0]    pipe_q;
   logic [CNT_W-1:0] stall_count_d;
   logic [CNT_W-1:0] stall_count_q;
   logic [CNT_W-1:0] flush_count_d;
   logic [CNT_W-1:0] flush_count_q;
   logic             load_use_s;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   assign d_bundle_s = {Valid_D, ALUASrc_D, ALUBSrc_D, DMWr_D, RUWr_D,
                        ALUOp_D, BrOp_D, DMCtrl_D, RUDATAWrSrc_D,
                        PC_D, RS1Data_D, RS2Data_D, Imm_D,
                        Rs1_D, Rs2_D, Rd_D};

   assign {Valid_E, ALUASrc_E, ALUBSrc_E, DMWr_E, RUWr_E,
           ALUOp_E, BrOp_E, DMCtrl_E, RUDATAWrSrc_E,
           PC_E, RS1Data_E, RS2Data_E, Imm_E,
           Rs1_E, Rs2_E, Rd_E} = pipe_q;

   assign StallCount = stall_count_q;
   assign FlushCount = flush_count_q;

   // Load in EX whose result the decode instruction needs; x0 is never a hazard.
   // Only the EX-stage instruction is compared, so a load reading its own Rd
   // never stalls itself.
   assign load_use_s = Valid_E && RUWr_E && (RUDATAWrSrc_E == 2'b01) &&
                       (Rd_E != 5'd0) && Valid_D &&
                       ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

   // Hold is deliberately not folded in: the front end ANDs Stall with Hold.
   assign Stall = load_use_s && !Flush && !Reset;

   // Next-state selection: Flush > Hold > load-use bubble > normal load.
   always_comb begin
      pipe_d        = pipe_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (Flush) begin
         // Flush counts even while Hold is asserted.
         pipe_d        = BUBBLE;
         flush_count_d = sat_inc(flush_count_q);
      end else if (Hold) begin
         pipe_d = pipe_q;
      end else if (load_use_s) begin
         pipe_d        = BUBBLE;
         stall_count_d = sat_inc(stall_count_q);
      end else begin
         pipe_d = d_bundle_s;
      end
   end

   // State registers with synchronous reset; reset discards the in-flight op.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pipe_q        <= BUBBLE;
         stall_count_q <= CNT_ZERO;
         flush_count_q <= CNT_ZERO;
      end else begin
         pipe_q        <= pipe_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Decode-to-execute pipeline register of the segmented RV32I core, directly downstream of Control_Unit and the register unit.
- Each cycle it captures the decode-stage control bundle (ALUASrc, ALUBSrc, ALUOp, BrOp, DMWr, DMCtrl, RUWr, RUDATAWrSrc) and the decode-stage operands, then presents them to the EX stage.
- Contains load-use hazard detection, which stalls IF/ID and inserts a bubble.
- Supports branch-redirect flush and a global hold, and keeps saturating stall and flush event counters.

Parameters:
- XLEN, 32, width of PC, operand and immediate fields
- CNT_W, 16, width of the StallCount and FlushCount counters

Ports:
- Clk  input  1  core clock, rising-edge
- Reset  input  1  synchronous, active-high reset
- Hold  input  1  freeze whole register (memory wait); contents unchanged
- Flush  input  1  branch/jump taken in EX; kill the instruction entering EX
- Valid_D  input  1  decode slot holds a real instruction
- ALUASrc_D, ALUBSrc_D, DMWr_D, RUWr_D  input  1 each  control from Control_Unit
- ALUOp_D  input  4  ALU operation
- BrOp_D  input  5  branch op; BrOp[4]=0 means no branch
- DMCtrl_D  input  3  data-memory access size/sign
- RUDATAWrSrc_D  input  2  00 ALU, 01 data memory, 10 PC+4
- PC_D, RS1Data_D, RS2Data_D, Imm_D  input  XLEN each  decode operands
- Rs1_D, Rs2_D, Rd_D  input  5 each  register indices
- <all *_D fields above>_E  output  same widths  registered EX-stage copies, including Valid_E
- Stall  output  1  combinational; freeze PC and IF/ID this cycle
- StallCount, FlushCount  output  CNT_W each  saturating event counters

Behaviour:
- All state updates on the rising edge of Clk.
- Priority, highest first: Reset > Flush > Hold > load-use bubble > normal load.
- Reset (synchronous):
  - all *_E outputs 0, including Valid_E=0, RUWr_E=0, DMWr_E=0, BrOp_E=0.
  - StallCount=0, FlushCount=0.
- Reset asserted mid-operation: discards the in-flight instruction on that edge; the counters clear too.
- LoadUse (combinational) is true only when all of the following hold:
  - Valid_E=1, RUWr_E=1, RUDATAWrSrc_E=01, Rd_E!=0
  - Valid_D=1
  - Rd_E==Rs1_D or Rd_E==Rs2_D
- Stall = LoadUse & ~Flush & ~Reset. Hold does not mask Stall; the front end ANDs the two.
- Bubble loads Valid_E=0, RUWr_E=0, DMWr_E=0, BrOp_E=0. All other *_E fields are zeroed.
- Flush loads a bubble. It overrides Hold and LoadUse; Stall is 0 in that cycle.
- Hold (without Flush) keeps every *_E field and both counters unchanged.
- Bubble cycle: a bubble is inserted when LoadUse is true and there is no Flush and no Hold. The decode instruction is re-presented next cycle because the front end stalls.
- Normal load: every *_E field takes its *_D value. Latency is exactly 1 cycle.
- A load whose Rd matches its own Rs1 causes no self-stall, because LoadUse compares against EX only.
- Counters:
  - StallCount += 1 on each edge where a bubble is inserted due to LoadUse.
  - FlushCount += 1 on each edge where Flush=1 and Reset=0, regardless of Hold.
  - Both saturate at 2^CNT_W-1 with no wrap; they are frozen under Hold except FlushCount as stated.
- Rd_E==0 never stalls, even for a load targeting x0.

Test Plan:
- Reset=1 for 2 cycles with random _D inputs -> all _E outputs 0, Stall=0, both counters 0.
- Present add x3,x1,x2 (RUWr_D=1, RUDATAWrSrc_D=00, ALUOp_D=0000, Valid_D=1), no hazard -> next cycle _E fields equal the _D values, Stall=0.
- Load-use stall:
  - Stimulus: lw x5 in EX (RUWr_E=1, RUDATAWrSrc_E=01, Rd_E=5), then decode add x6,x5,x7.
  - Response: Stall=1 for exactly 1 cycle, next Valid_E=0, RUWr_E=0, DMWr_E=0, StallCount=1; the following cycle, add appears in EX.
- lw x0 in EX with Rs1_D=0 -> Stall=0, no bubble.
- Flush=1 simultaneously with the load-use condition and Hold=1 -> Stall=0, next Valid_E=0, BrOp_E=0, FlushCount=1, StallCount unchanged.
- Hold=1 for 3 cycles with changing _D -> _E outputs stable; preload StallCount=0xFFFE, then 2 bubbles -> 0xFFFF, no wrap.
